// File: rtl/obstacle_scheduler_if.sv
// Frame-control inputs and renderer-facing outputs of the runner game sequencer.
interface obstacle_scheduler_if;
  logic       frame_tick;
  logic       start_btn;
  logic       collision;
  logic [9:0] x_offset;
  logic [9:0] u_x_pos;
  logic [9:0] u_y_pos;
  logic       u_active;
  logic       sin_active;
  logic       show_player;
  logic [1:0] game_state;
  logic [7:0] score;

  modport master (
    output frame_tick, start_btn, collision,
    input  x_offset, u_x_pos, u_y_pos, u_active, sin_active, show_player, game_state, score
  );

  modport slave (
    input  frame_tick, start_btn, collision,
    output x_offset, u_x_pos, u_y_pos, u_active, sin_active, show_player, game_state, score
  );
endinterface

// File: rtl/obstacle_scheduler.sv
// Per-frame game sequencer: scroll, obstacle spawn/retire, IDLE/RUN/DEAD, score.
// Outputs registered, visible the cycle after frame_tick; no backpressure, every tick is consumed.
module obstacle_scheduler #(
  parameter int SCROLL_SPEED = 4,
  parameter int SCREEN_W     = 640,
  parameter int SPAWN_X      = 600,
  parameter int SPAWN_GAP    = 90,
  parameter int SIN_FRAMES   = 120,
  parameter int DEAD_FRAMES  = 120,
  parameter int BLINK_FRAMES = 8
) (
  input logic               clk,
  input logic               rst_n,
  obstacle_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DEAD = 2'd2} state_t;

  localparam logic [9:0]  SPEED_V   = 10'(SCROLL_SPEED);
  localparam logic [10:0] SPEED_W   = 11'(SCROLL_SPEED);
  localparam logic [10:0] SCREEN_V  = 11'(SCREEN_W);
  localparam logic [9:0]  SPAWN_X_V = 10'(SPAWN_X);
  localparam logic [7:0]  GAP_V     = 8'(SPAWN_GAP);
  localparam logic [7:0]  SIN_V     = 8'(SIN_FRAMES);
  localparam logic [7:0]  DEAD_V    = 8'(DEAD_FRAMES);
  localparam logic [7:0]  BLINK_V   = 8'(BLINK_FRAMES);

  state_t     state, state_n;
  logic [9:0] x_offset, x_offset_n;
  logic [9:0] u_x_pos, u_x_pos_n;
  logic [9:0] u_y_pos, u_y_pos_n;
  logic       u_active, u_active_n;
  logic       sin_active, sin_active_n;
  logic       show_player, show_player_n;
  logic [7:0] score, score_n;
  logic [7:0] spawn_cnt, spawn_cnt_n;
  logic [7:0] sin_cnt, sin_cnt_n;
  logic [7:0] dead_cnt, dead_cnt_n;
  logic [7:0] blink_cnt, blink_cnt_n;
  logic       next_sin, next_sin_n;
  logic [7:0] lfsr;
  logic       hit_latch;
  logic       hit;
  logic [10:0] x_sum;
  logic [1:0]  gain;
  logic [8:0]  score_sum;

  // A hit arriving on the tick cycle itself must still end the run.
  assign hit = hit_latch | bus.collision;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= 8'hA5;
      hit_latch <= 1'b0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (bus.frame_tick)
        hit_latch <= 1'b0;
      else if (bus.collision)
        hit_latch <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      x_offset    <= '0;
      u_x_pos     <= SPAWN_X_V;
      u_y_pos     <= 10'd200;
      u_active    <= 1'b0;
      sin_active  <= 1'b0;
      show_player <= 1'b1;
      score       <= '0;
      spawn_cnt   <= '0;
      sin_cnt     <= '0;
      dead_cnt    <= '0;
      blink_cnt   <= '0;
      next_sin    <= 1'b0;
    end else begin
      state       <= state_n;
      x_offset    <= x_offset_n;
      u_x_pos     <= u_x_pos_n;
      u_y_pos     <= u_y_pos_n;
      u_active    <= u_active_n;
      sin_active  <= sin_active_n;
      show_player <= show_player_n;
      score       <= score_n;
      spawn_cnt   <= spawn_cnt_n;
      sin_cnt     <= sin_cnt_n;
      dead_cnt    <= dead_cnt_n;
      blink_cnt   <= blink_cnt_n;
      next_sin    <= next_sin_n;
    end
  end

  always_comb begin
    state_n       = state;
    x_offset_n    = x_offset;
    u_x_pos_n     = u_x_pos;
    u_y_pos_n     = u_y_pos;
    u_active_n    = u_active;
    sin_active_n  = sin_active;
    show_player_n = show_player;
    score_n       = score;
    spawn_cnt_n   = spawn_cnt;
    sin_cnt_n     = sin_cnt;
    dead_cnt_n    = dead_cnt;
    blink_cnt_n   = blink_cnt;
    next_sin_n    = next_sin;
    x_sum         = '0;
    gain          = '0;
    score_sum     = '0;

    if (bus.frame_tick) begin
      case (state)
        RUN: begin
          if (hit) begin
            state_n     = DEAD;
            dead_cnt_n  = DEAD_V;
            blink_cnt_n = '0;
          end else begin
            x_sum      = {1'b0, x_offset} + SPEED_W;
            x_offset_n = (x_sum >= SCREEN_V) ? 10'(x_sum - SCREEN_V) : x_sum[9:0];

            if (u_active) begin
              if (u_x_pos < SPEED_V) begin
                u_active_n = 1'b0;
                gain       = gain + 2'd1;
              end else begin
                u_x_pos_n = u_x_pos - SPEED_V;
              end
            end

            if (sin_cnt != '0) begin
              sin_cnt_n = sin_cnt - 8'd1;
              if (sin_cnt == 8'd1)
                gain = gain + 2'd1;
            end
            sin_active_n = (sin_cnt_n != '0);

            score_sum = {1'b0, score} + {7'd0, gain};
            score_n   = score_sum[8] ? 8'hFF : score_sum[7:0];

            // Spawn decisions see the slots as freed by this frame's retirements.
            if (spawn_cnt != '0) begin
              spawn_cnt_n = spawn_cnt - 8'd1;
            end else if (!next_sin && !u_active_n) begin
              u_x_pos_n   = SPAWN_X_V;
              u_y_pos_n   = 10'd200 + {8'd0, lfsr[1:0]} * 10'd40;
              u_active_n  = 1'b1;
              next_sin_n  = 1'b1;
              spawn_cnt_n = GAP_V;
            end else if (next_sin && sin_cnt_n == '0) begin
              sin_cnt_n    = SIN_V;
              sin_active_n = 1'b1;
              next_sin_n   = 1'b0;
              spawn_cnt_n  = GAP_V;
            end
          end
        end
        DEAD: begin
          dead_cnt_n = dead_cnt - 8'd1;
          if (blink_cnt == BLINK_V - 8'd1) begin
            blink_cnt_n   = '0;
            show_player_n = ~show_player;
          end else begin
            blink_cnt_n = blink_cnt + 8'd1;
          end
          if (dead_cnt == 8'd1) begin
            state_n       = IDLE;
            u_active_n    = 1'b0;
            sin_active_n  = 1'b0;
            sin_cnt_n     = '0;
            show_player_n = 1'b1;
          end
        end
        default: begin
          if (bus.start_btn) begin
            state_n     = RUN;
            score_n     = '0;
            x_offset_n  = '0;
            spawn_cnt_n = GAP_V;
            next_sin_n  = 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.x_offset    = x_offset;
  assign bus.u_x_pos     = u_x_pos;
  assign bus.u_y_pos     = u_y_pos;
  assign bus.u_active    = u_active;
  assign bus.sin_active  = sin_active;
  assign bus.show_player = show_player;
  assign bus.game_state  = state;
  assign bus.score       = score;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// Randomised bench: a frame-level reference model queues expected outputs, a monitor compares them.
module tb_obstacle_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  obstacle_scheduler_if bus ();
  obstacle_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int xoff; int ux; int uy; int score; int gs;
    bit uact; bit sact; bit show;
  } snap_t;

  snap_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state (frame-level game rules)
  int m_state, m_xoff, m_ux, m_uy, m_score, m_spawn, m_sin, m_dead, m_blink;
  bit m_uact, m_show, m_next_sin, m_latch, m_hit;
  logic [7:0] m_lfsr;

  task automatic push_snap();
    snap_t s;
    s.xoff = m_xoff; s.ux = m_ux; s.uy = m_uy; s.score = m_score; s.gs = m_state;
    s.uact = m_uact; s.sact = (m_sin != 0); s.show = m_show;
    exp_q.push_back(s);
  endtask

  task automatic model_frame(input bit hit, input bit start);
    int gain;
    if (m_state == 0) begin
      if (start) begin
        m_state = 1; m_score = 0; m_xoff = 0; m_spawn = 90; m_next_sin = 0;
      end
    end else if (m_state == 1) begin
      if (hit) begin
        m_state = 2; m_dead = 120; m_blink = 0;
      end else begin
        m_xoff = (m_xoff + 4) % 640;
        gain = 0;
        if (m_uact) begin
          if (m_ux < 4) begin m_uact = 0; gain++; end
          else m_ux -= 4;
        end
        if (m_sin != 0) begin
          m_sin--;
          if (m_sin == 0) gain++;
        end
        m_score = (m_score + gain > 255) ? 255 : m_score + gain;
        if (m_spawn != 0) m_spawn--;
        else if (!m_next_sin && !m_uact) begin
          m_ux = 600; m_uy = 200 + 40 * int'(m_lfsr % 4); m_uact = 1;
          m_next_sin = 1; m_spawn = 90;
        end else if (m_next_sin && m_sin == 0) begin
          m_sin = 120; m_next_sin = 0; m_spawn = 90;
        end
      end
    end else begin
      m_dead--;
      m_blink++;
      if (m_blink == 8) begin m_blink = 0; m_show = !m_show; end
      if (m_dead == 0) begin
        m_state = 0; m_uact = 0; m_sin = 0; m_show = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_state = 0; m_xoff = 0; m_ux = 600; m_uy = 200; m_score = 0; m_spawn = 0;
      m_sin = 0; m_dead = 0; m_blink = 0; m_uact = 0; m_show = 1; m_next_sin = 0;
      m_latch = 0; m_lfsr = 8'hA5;
      push_snap();
    end else begin
      m_hit = m_latch || bus.collision;
      if (bus.frame_tick) begin
        model_frame(m_hit, bus.start_btn);
        push_snap();
      end
      m_latch = !bus.frame_tick && (m_latch || bus.collision);
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end
  end

  // Monitor: a frame_tick (or reset) at a rising edge means fresh outputs by the falling edge.
  initial begin
    bit   ev;
    snap_t e;
    forever begin
      @(posedge clk);
      ev = !rst_n || bus.frame_tick;
      @(negedge clk);
      if (ev) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL no_expected_entry vector=%0d", vectors);
        end else begin
          e = exp_q.pop_front();
          if (bus.x_offset !== 10'(e.xoff) || bus.u_x_pos !== 10'(e.ux) ||
              bus.u_y_pos !== 10'(e.uy) || bus.score !== 8'(e.score) ||
              bus.game_state !== 2'(e.gs) || bus.u_active !== e.uact ||
              bus.sin_active !== e.sact || bus.show_player !== e.show) begin
            miscompares++;
            $display("FAIL frame_outputs vector=%0d got gs=%0d x=%0d ux=%0d uy=%0d ua=%0b sa=%0b sp=%0b sc=%0d want gs=%0d x=%0d ux=%0d uy=%0d ua=%0b sa=%0b sp=%0b sc=%0d",
                     vectors, bus.game_state, bus.x_offset, bus.u_x_pos, bus.u_y_pos,
                     bus.u_active, bus.sin_active, bus.show_player, bus.score,
                     e.gs, e.xoff, e.ux, e.uy, e.uact, e.sact, e.show, e.score);
          end
        end
      end
    end
  end

  task automatic cyc(input bit tick, input bit start, input bit coll);
    @(posedge clk);
    #2;
    bus.frame_tick = tick;
    bus.start_btn  = start;
    bus.collision  = coll;
  endtask

  // gap idle cycles (optionally with a mid-frame hit), then one tick cycle
  task automatic frame(input int gap, input bit start, input bit coll_mid, input bit coll_tick);
    for (int i = 0; i < gap; i++)
      cyc(1'b0, start, coll_mid && (i == gap / 2));
    cyc(1'b1, start, coll_tick);
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.start_btn  = 1'b0;
    bus.collision  = 1'b0;
    rst_n = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    @(posedge clk); #2; rst_n = 1'b1;

    repeat (3) frame($urandom_range(1, 4), 1'b0, 1'b0, 1'b0);
    frame(2, 1'b1, 1'b0, 1'b0);
    repeat (420) frame($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 1'b0);

    frame(4, 1'b0, 1'b1, 1'b0);
    repeat (130) frame($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 9) == 0), 1'b0);

    // Random soak: starts, hits and idle periods interleaved
    repeat (900) frame($urandom_range(0, 4), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 199) == 0), ($urandom_range(0, 299) == 0));

    for (int i = 0; i < 300 && m_state != 1; i++)
      frame($urandom_range(0, 2), 1'b1, 1'b0, 1'b0);
    repeat (20) frame($urandom_range(0, 2), 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) cyc(1'b1, 1'b1, 1'b0);
    @(posedge clk); #2; rst_n = 1'b1; bus.frame_tick = 1'b0;

    // Long uninterrupted run drives the score into saturation
    frame(1, 1'b1, 1'b0, 1'b0);
    repeat (24000) frame(0, 1'b0, 1'b0, 1'b0);
    frame(0, 1'b0, 1'b0, 1'b1);
    repeat (125) frame($urandom_range(0, 1), 1'b1, 1'b0, 1'b0);

    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expected count=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
